ram_loader: RTL
===============

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 The block SHALL have parameter AddressSize, default 16, RAM address width.
REQ-002 The block SHALL have parameter WordSize, default 8, RAM data width.
REQ-003 The block SHALL have port clk  input  1  single clock, all state changes on posedge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  begin a load; sampled in IDLE only.
REQ-006 The block SHALL have port start_addr  input  AddressSize  first RAM address, captured on start.
REQ-007 The block SHALL have port length  input  AddressSize  byte count, captured on start.
REQ-008 The block SHALL have port verify_en  input  1  read-back check after writing, captured on start.
REQ-009 The block SHALL have port in_valid / in_data  input  1 / WordSize  upstream byte stream.
REQ-010 The block SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-011 The block SHALL have ports RamAddress / RamInData  output  AddressSize / WordSize  registered RAM address and write data.
REQ-012 The block SHALL have port RamOutData  input  WordSize  RAM read data, combinational from the RAM.
REQ-013 The block SHALL have ports RamCS, RamWE, RamOE  output  1 each  active-low RAM controls, registered.
REQ-014 The block SHALL have ports busy, done, error, checksum  output  1/1/1/WordSize  status.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, WRITE, VERIFY, DONE.
REQ-016 IDLE: start=1 -> capture start_addr, length and verify_en, clear checksum and error; if length==0 -> DONE, else -> LOAD.
REQ-017 LOAD: in_ready=1; on handshake -> latch in_data into RamInData, checksum += in_data mod 2^WordSize, -> WRITE.
REQ-018 WRITE: one cycle with RamCS=0, RamWE=0, RamOE=1; the RAM captures on the next posedge; in_ready=0.
REQ-019 After WRITE: RamAddress+1, wrapping from all-ones to 0; remaining count -1; count==0 -> VERIFY (verify_en=1, RamAddress reloaded to start_addr, read sum cleared) or DONE; else -> LOAD.
REQ-020 VERIFY: RamCS=0, RamOE=0, RamWE=1; one byte per cycle; read sum += RamOutData; address increments with wrap; after length reads -> DONE.
REQ-021 On VERIFY exit, error SHALL be set if read sum != checksum.
REQ-022 DONE: done=1 for exactly one cycle -> IDLE; error and checksum hold until the next start.
REQ-023 busy SHALL be 1 in LOAD, WRITE, VERIFY and DONE.
REQ-024 RamWE and RamOE SHALL never both be 0; outside WRITE/VERIFY, RamCS=RamWE=RamOE=1.
REQ-025 start while busy SHALL be ignored; in_valid outside LOAD SHALL be ignored.
REQ-026 Minimum load time SHALL be 2 cycles per byte, plus length cycles when verify_en=1, plus 1 DONE cycle.

Reset
REQ-027 reset=1 SHALL force IDLE immediately, regardless of the clock, including mid-load.
REQ-028 During reset: RamCS=RamWE=RamOE=1; RamAddress, RamInData, checksum and count =0; in_ready=busy=done=error=0.

Structure
REQ-029 FSM state encoding SHALL be in a shared package, loader_pkg, with no other contents.
REQ-030 No sub-module SHALL be used; the checksum/read-sum adder is inline.

Verification
REQ-031 Load 4 bytes 01,02,03,04 at start_addr 0x0100, verify_en=0 -> RAM 0x0100..0x0103 hold 01..04, checksum=0A, done pulse, error=0.
REQ-032 Same load with verify_en=1 -> 4 VERIFY cycles with RamOE=0 and RamWE=1, error=0; forcing RAM[0x0102]=FF before VERIFY -> error=1.
REQ-033 start_addr=0xFFFE, 3 bytes AA,BB,CC -> written to 0xFFFE, 0xFFFF, 0x0000; checksum=31.
REQ-034 length=0 -> done one cycle after start, no RAM access (RamCS stays 1), checksum=00.
REQ-035 in_valid toggled randomly during an 8-byte load -> exactly 8 writes in order; start pulses while busy -> no effect.
REQ-036 reset asserted during WRITE of byte 2 -> RamCS/RamWE high in the same cycle, IDLE, all outputs 0; a following start begins a clean load.

Source files
------------

// File: rtl/loader_pkg.sv
// State encoding for the RAM loader FSM.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WRITE  = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/ram_loader.sv
// Streams a byte block into a single-port RAM at a start address, then reads
// it back and compares the read sum against the write checksum.
module ram_loader
    import loader_pkg::*;
#(
    parameter int unsigned AddressSize = 16,
    parameter int unsigned WordSize    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [AddressSize-1:0] start_addr,
    input  logic [AddressSize-1:0] length,
    input  logic                   verify_en,
    input  logic                   in_valid,
    input  logic [WordSize-1:0]    in_data,
    output logic                   in_ready,
    output logic [AddressSize-1:0] RamAddress,
    output logic [WordSize-1:0]    RamInData,
    input  logic [WordSize-1:0]    RamOutData,
    output logic                   RamCS,
    output logic                   RamWE,
    output logic                   RamOE,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [WordSize-1:0]    checksum
);

    state_t                 r_state, w_state_nxt;
    logic [AddressSize-1:0] r_addr, w_addr_nxt;
    logic [AddressSize-1:0] r_start_addr, w_start_addr_nxt;
    logic [AddressSize-1:0] r_len, w_len_nxt;
    logic [AddressSize-1:0] r_count, w_count_nxt;
    logic [AddressSize-1:0] w_count_dec;
    logic                   r_verify, w_verify_nxt;
    logic [WordSize-1:0]    r_wdata, w_wdata_nxt;
    logic [WordSize-1:0]    r_checksum, w_checksum_nxt;
    logic [WordSize-1:0]    r_rsum, w_rsum_nxt;
    logic [WordSize-1:0]    w_rsum_sum;
    logic                   r_error, w_error_nxt;
    logic                   r_cs, w_cs_nxt;
    logic                   r_we, w_we_nxt;
    logic                   r_oe, w_oe_nxt;
    logic                   r_in_ready, w_in_ready_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;

    assign w_count_dec = r_count - AddressSize'(1);
    assign w_rsum_sum  = r_rsum + RamOutData;

    // Next-state and datapath; output strobes are derived from the next state
    // so the registered controls line up with the state they belong to.
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_start_addr_nxt = r_start_addr;
        w_len_nxt        = r_len;
        w_count_nxt      = r_count;
        w_verify_nxt     = r_verify;
        w_wdata_nxt      = r_wdata;
        w_checksum_nxt   = r_checksum;
        w_rsum_nxt       = r_rsum;
        w_error_nxt      = r_error;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_addr_nxt = start_addr;
                    w_addr_nxt       = start_addr;
                    w_len_nxt        = length;
                    w_count_nxt      = length;
                    w_verify_nxt     = verify_en;
                    w_checksum_nxt   = '0;
                    w_error_nxt      = 1'b0;
                    w_state_nxt      = (length == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (in_valid && r_in_ready) begin
                    w_wdata_nxt    = in_data;
                    w_checksum_nxt = r_checksum + in_data;
                    w_state_nxt    = WRITE;
                end
            end
            WRITE: begin
                w_addr_nxt  = r_addr + AddressSize'(1);
                w_count_nxt = w_count_dec;
                if (w_count_dec != '0) begin
                    w_state_nxt = LOAD;
                end else if (r_verify) begin
                    w_addr_nxt  = r_start_addr;
                    w_count_nxt = r_len;
                    w_rsum_nxt  = '0;
                    w_state_nxt = VERIFY;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            VERIFY: begin
                w_rsum_nxt  = w_rsum_sum;
                w_addr_nxt  = r_addr + AddressSize'(1);
                w_count_nxt = w_count_dec;
                if (w_count_dec == '0) begin
                    w_error_nxt = (w_rsum_sum != r_checksum);
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_cs_nxt       = !((w_state_nxt == WRITE) || (w_state_nxt == VERIFY));
        w_we_nxt       = (w_state_nxt != WRITE);
        w_oe_nxt       = (w_state_nxt != VERIFY);
        w_in_ready_nxt = (w_state_nxt == LOAD);
        w_busy_nxt     = (w_state_nxt != IDLE);
        w_done_nxt     = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_start_addr <= '0;
            r_len        <= '0;
            r_count      <= '0;
            r_verify     <= 1'b0;
            r_wdata      <= '0;
            r_checksum   <= '0;
            r_rsum       <= '0;
            r_error      <= 1'b0;
            r_cs         <= 1'b1;
            r_we         <= 1'b1;
            r_oe         <= 1'b1;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_start_addr <= w_start_addr_nxt;
            r_len        <= w_len_nxt;
            r_count      <= w_count_nxt;
            r_verify     <= w_verify_nxt;
            r_wdata      <= w_wdata_nxt;
            r_checksum   <= w_checksum_nxt;
            r_rsum       <= w_rsum_nxt;
            r_error      <= w_error_nxt;
            r_cs         <= w_cs_nxt;
            r_we         <= w_we_nxt;
            r_oe         <= w_oe_nxt;
            r_in_ready   <= w_in_ready_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign in_ready   = r_in_ready;
    assign RamAddress = r_addr;
    assign RamInData  = r_wdata;
    assign RamCS      = r_cs;
    assign RamWE      = r_we;
    assign RamOE      = r_oe;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign checksum   = r_checksum;

endmodule
